// File: rtl/ram_fifo_stream_pkg.sv
// Shared width helpers and geometry check for the RAM-backed streaming FIFO.
package ram_fifo_stream_pkg;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 32'sd1;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 32'sd2;
  endfunction

  function automatic bit depth_ok(input int addr_width, input int depth);
    return depth == (32'sd1 << addr_width);
  endfunction

endpackage

// File: rtl/ram_sync_1r1w.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module ram_sync_1r1w
  import ram_fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port: data appears one edge after ren.
  always_ff @(posedge clk) begin
    if (ren) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ram_fifo_stream.sv
// Valid/ready FIFO over ram_sync_1r1w; a two-slot output queue plus one
// in-flight read hide the RAM read latency for one word per cycle.
module ram_fifo_stream
  import ram_fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int CNT_W = count_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  generate
    if (!depth_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_depth
      $error("ram_fifo_stream: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [PTR_W-1:0]      wptr_r, rptr_r;
  logic                  rd_pend_r;
  logic                  ob0_vld_r, ob1_vld_r;
  logic [DATA_WIDTH-1:0] ob0_data_r, ob1_data_r;
  logic [CNT_W-1:0]      count_r;
  logic                  wr_ready_r;

  logic [PTR_W-1:0]      ram_count_s, wptr_n_s, rptr_n_s, ram_count_n_s;
  logic                  push_s, pop_s, issue_s;
  logic [1:0]            load_s, load_after_s;
  logic                  sh0_vld_s, sh1_vld_s;
  logic [DATA_WIDTH-1:0] sh0_data_s, sh1_data_s;
  logic                  ob0_vld_n_s, ob1_vld_n_s;
  logic [DATA_WIDTH-1:0] ob0_data_n_s, ob1_data_n_s;
  logic [CNT_W-1:0]      count_n_s;
  logic                  wr_ready_n_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // Handshakes and read-issue decision from registered state.
  always_comb begin
    ram_count_s  = wptr_r - rptr_r;
    push_s       = wr_valid && wr_ready_r;
    pop_s        = ob0_vld_r && rd_ready;
    load_s       = {1'b0, ob0_vld_r} + {1'b0, ob1_vld_r} + {1'b0, rd_pend_r};
    load_after_s = load_s - {1'b0, pop_s};
    issue_s      = (ram_count_s != {PTR_W{1'b0}}) && (load_after_s < 2'd2);
  end

  // Output queue: apply the pop shift first, then land returning RAM data.
  always_comb begin
    if (pop_s) begin
      sh0_vld_s  = ob1_vld_r;
      sh0_data_s = ob1_data_r;
      sh1_vld_s  = 1'b0;
      sh1_data_s = ob1_data_r;
    end else begin
      sh0_vld_s  = ob0_vld_r;
      sh0_data_s = ob0_data_r;
      sh1_vld_s  = ob1_vld_r;
      sh1_data_s = ob1_data_r;
    end

    if (rd_pend_r && !sh0_vld_s) begin
      ob0_vld_n_s  = 1'b1;
      ob0_data_n_s = ram_rdata_s;
      ob1_vld_n_s  = sh1_vld_s;
      ob1_data_n_s = sh1_data_s;
    end else if (rd_pend_r) begin
      ob0_vld_n_s  = sh0_vld_s;
      ob0_data_n_s = sh0_data_s;
      ob1_vld_n_s  = 1'b1;
      ob1_data_n_s = ram_rdata_s;
    end else begin
      ob0_vld_n_s  = sh0_vld_s;
      ob0_data_n_s = sh0_data_s;
      ob1_vld_n_s  = sh1_vld_s;
      ob1_data_n_s = sh1_data_s;
    end
  end

  // Next pointers plus count/wr_ready precomputed so both leave flops.
  always_comb begin
    wptr_n_s      = wptr_r + {{(PTR_W-1){1'b0}}, push_s};
    rptr_n_s      = rptr_r + {{(PTR_W-1){1'b0}}, issue_s};
    ram_count_n_s = wptr_n_s - rptr_n_s;
    count_n_s     = {1'b0, ram_count_n_s}
                  + {{(CNT_W-1){1'b0}}, issue_s}
                  + {{(CNT_W-1){1'b0}}, ob0_vld_n_s}
                  + {{(CNT_W-1){1'b0}}, ob1_vld_n_s};
    wr_ready_n_s  = ram_count_n_s < DEPTH_P;
  end

  // State registers; reset discards every held word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r     <= {PTR_W{1'b0}};
      rptr_r     <= {PTR_W{1'b0}};
      rd_pend_r  <= 1'b0;
      ob0_vld_r  <= 1'b0;
      ob1_vld_r  <= 1'b0;
      ob0_data_r <= {DATA_WIDTH{1'b0}};
      ob1_data_r <= {DATA_WIDTH{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      wr_ready_r <= 1'b1;
    end else begin
      wptr_r     <= wptr_n_s;
      rptr_r     <= rptr_n_s;
      rd_pend_r  <= issue_s;
      ob0_vld_r  <= ob0_vld_n_s;
      ob1_vld_r  <= ob1_vld_n_s;
      ob0_data_r <= ob0_data_n_s;
      ob1_data_r <= ob1_data_n_s;
      count_r    <= count_n_s;
      wr_ready_r <= wr_ready_n_s;
    end
  end

  ram_sync_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wptr_r[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .ren   (issue_s),
    .raddr (rptr_r[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata_s)
  );

  assign wr_ready = wr_ready_r;
  assign rd_valid = ob0_vld_r;
  assign rd_data  = ob0_data_r;
  assign count    = count_r;

endmodule
